// File: rtl/demux1to4_stream_param.sv
// demux1to4_stream_param: routes a valid/ready word stream to one of four registered output channels
module demux1to4_stream_param #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rr_en,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [1:0]   rr_ptr,
    output logic [N-1:0] a_data,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [N-1:0] b_data,
    output logic         b_valid,
    input  logic         b_ready,
    output logic [N-1:0] c_data,
    output logic         c_valid,
    input  logic         c_ready,
    output logic [N-1:0] d_data,
    output logic         d_valid,
    input  logic         d_ready
);
    logic [N-1:0] data_q [4];
    logic [N-1:0] data_d [4];
    logic [3:0]   valid_q, valid_d, rdy;
    logic [1:0]   rr_ptr_q, rr_ptr_d, dest;
    logic         acc;
    assign rdy = {d_ready, c_ready, b_ready, a_ready};
    always_comb begin
        dest     = rr_en ? rr_ptr_q : in_sel;
        in_ready = ~valid_q[dest] | rdy[dest];
        acc      = in_valid & in_ready;
        rr_ptr_d = (acc & rr_en) ? rr_ptr_q + 2'd1 : rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            valid_d[i] = (acc && dest == 2'(i)) | (valid_q[i] & ~rdy[i]);
            data_d[i]  = (acc && dest == 2'(i)) ? in_data : data_q[i];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < 4; i++) data_q[i] <= '0;
        end else begin
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < 4; i++) data_q[i] <= data_d[i];
        end
    end
    assign rr_ptr  = rr_ptr_q;
    assign a_data  = data_q[0];
    assign b_data  = data_q[1];
    assign c_data  = data_q[2];
    assign d_data  = data_q[3];
    assign a_valid = valid_q[0];
    assign b_valid = valid_q[1];
    assign c_valid = valid_q[2];
    assign d_valid = valid_q[3];
endmodule

// File: tb/tb_demux1to4_stream_param.sv
// tb_demux1to4_stream_param: directed and random checks against a per-channel slot model
module tb_demux1to4_stream_param;
    localparam int N = 8;
    logic         clk = 0;
    logic         rst_n, rr_en, in_valid;
    logic [N-1:0] in_data;
    logic [1:0]   in_sel;
    logic [3:0]   rdy;
    logic         in_ready;
    logic [1:0]   rr_ptr;
    logic [N-1:0] a_data, b_data, c_data, d_data;
    logic         a_valid, b_valid, c_valid, d_valid;
    logic [N-1:0] od [4];
    logic [3:0]   ov;
    int           n_checks = 0, n_err = 0;
    logic [N-1:0] m_data [4];
    bit           m_valid [4];
    int           m_ptr;

    always #5 clk = ~clk;

    demux1to4_stream_param #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .rr_en(rr_en), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .rr_ptr(rr_ptr),
        .a_data(a_data), .a_valid(a_valid), .a_ready(rdy[0]),
        .b_data(b_data), .b_valid(b_valid), .b_ready(rdy[1]),
        .c_data(c_data), .c_valid(c_valid), .c_ready(rdy[2]),
        .d_data(d_data), .d_valid(d_valid), .d_ready(rdy[3])
    );

    assign od[0] = a_data;
    assign od[1] = b_data;
    assign od[2] = c_data;
    assign od[3] = d_data;
    assign ov    = {d_valid, c_valid, b_valid, a_valid};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        int  d;
        bit  er, acc;
        #1;
        d  = rr_en ? m_ptr : int'(in_sel);
        er = !m_valid[d] || rdy[d];
        if (rst_n) chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        acc = in_valid && er && rst_n;
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0;
            for (int i = 0; i < 4; i++) begin
                m_valid[i] = 0;
                m_data[i]  = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++)
                if (m_valid[i] && rdy[i]) m_valid[i] = 0;
            if (acc) begin
                m_valid[d] = 1;
                m_data[d]  = in_data;
                if (rr_en) m_ptr = (m_ptr + 1) % 4;
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid%0d", i), {31'd0, ov[i]}, {31'd0, m_valid[i]});
            chk($sformatf("data%0d", i), {24'd0, od[i]}, {24'd0, m_data[i]});
        end
        chk("rr_ptr", {30'd0, rr_ptr}, 32'(m_ptr));
    endtask

    initial begin
        m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_data[i]  = '0;
        end
        rst_n = 0; rr_en = 0; in_valid = 1; in_data = 8'hEE; in_sel = 0; rdy = 4'h0;
        cyc();
        cyc();
        rst_n = 1; in_valid = 0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_sel = 2'(i); in_data = 8'(8'h11 * (i + 1));
            cyc();
        end
        in_valid = 1; in_data = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i);
            cyc();
            chk("full_ready", {31'd0, in_ready}, 32'd0);
        end
        in_sel = 1; in_data = 8'h5A;
        for (int i = 0; i < 5; i++) cyc();
        chk("b_stable", {24'd0, b_data}, 32'h22);
        rdy = 4'b0010;
        cyc();
        chk("b_new", {24'd0, b_data}, 32'h5A);
        rdy = 4'hF; in_valid = 0;
        cyc();
        rr_en = 1; in_valid = 1;
        for (int i = 1; i <= 6; i++) begin
            in_data = 8'(i); in_sel = 2'($urandom_range(0, 3));
            cyc();
        end
        chk("rr_wrap", {30'd0, rr_ptr}, 32'd2);
        rr_en = 0; in_sel = 2; in_data = 8'h77; rdy = 4'b1011;
        cyc();
        rr_en = 1; in_data = 8'h88; in_sel = 3;
        for (int i = 0; i < 3; i++) cyc();
        chk("rr_hold", {30'd0, rr_ptr}, 32'd2);
        rdy = 4'hF;
        cyc();
        chk("rr_c_data", {24'd0, c_data}, 32'h88);
        chk("rr_adv", {30'd0, rr_ptr}, 32'd3);
        rr_en = 0; rdy = 4'h0;
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i); in_data = 8'(8'hA0 + i);
            cyc();
        end
        rst_n = 0;
        cyc();
        rst_n = 1; in_sel = 2; in_data = 8'h99;
        cyc();
        chk("post_rst_c", {24'd0, c_data}, 32'h99);
        for (int k = 0; k < 300; k++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            rr_en    = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = 8'($urandom);
            rdy      = 4'($urandom);
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
